instr_sequencer: RTL and testbench

Multi-cycle control sequencer for the 8-bit accumulator CPU. It fetches instruction bytes from program memory over a req/ack handshake, decodes them, drives the ALU operand and select lines, and writes results back to the accumulator. It replaces bench-driven stimulus as the master of the ALU/accumulator interface and sits between program memory and the `alu`/`accumulator` instances.

---
 rtl/cpu_pkg.sv | 35 +++
 rtl/instr_decode.sv | 38 +++
 rtl/instr_sequencer.sv | 140 ++++++++++++++
 tb/tb_instr_sequencer.sv | 323 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit accumulator CPU: opcodes, ALU selects,
// instruction field widths and the sequencer state type.
package cpu_pkg;

    localparam int unsigned OPCODE_W  = 4;
    localparam int unsigned DATA_W    = 8;
    localparam int unsigned ALU_SEL_W = 4;

    localparam logic [OPCODE_W-1:0] OP_NOP  = 4'h0;
    localparam logic [OPCODE_W-1:0] OP_ADD  = 4'h1;
    localparam logic [OPCODE_W-1:0] OP_MUL  = 4'h2;
    localparam logic [OPCODE_W-1:0] OP_AND  = 4'h3;
    localparam logic [OPCODE_W-1:0] OP_OR   = 4'h4;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 4'h5;
    localparam logic [OPCODE_W-1:0] OP_LDI  = 4'h6;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 4'h7;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 4'h8;
    localparam logic [OPCODE_W-1:0] OP_HALT = 4'hF;

    localparam logic [ALU_SEL_W-1:0] ALU_ADD  = 4'b0000;
    localparam logic [ALU_SEL_W-1:0] ALU_MUL  = 4'b0001;
    localparam logic [ALU_SEL_W-1:0] ALU_AND  = 4'b0010;
    localparam logic [ALU_SEL_W-1:0] ALU_OR   = 4'b0011;
    localparam logic [ALU_SEL_W-1:0] ALU_NOT  = 4'b0100;
    localparam logic [ALU_SEL_W-1:0] ALU_PASS = 4'b0111;

    typedef enum logic [2:0] {
        ST_FETCH,
        ST_DECODE,
        ST_IMM,
        ST_EXEC,
        ST_HALT
    } seq_state_t;

endpackage

// File: rtl/instr_decode.sv
// Combinational opcode decoder for instr_sequencer.
// JMP/JZ decode as two-byte branches only when SEQ_BRANCH_EN is defined.
module instr_decode
    import cpu_pkg::*;
(
    input  logic [OPCODE_W-1:0]  opcode,
    output logic                 is_two_byte,
    output logic                 is_alu,
    output logic [ALU_SEL_W-1:0] alu_select,
    output logic                 is_branch,
    output logic                 is_halt,
    output logic                 is_illegal
);

    always_comb begin
        is_two_byte = 1'b0;
        is_alu      = 1'b0;
        alu_select  = ALU_ADD;
        is_branch   = 1'b0;
        is_halt     = 1'b0;
        is_illegal  = 1'b0;
        case (opcode)
            OP_NOP:  ;
            OP_ADD:  begin is_two_byte = 1'b1; is_alu = 1'b1; alu_select = ALU_ADD;  end
            OP_MUL:  begin is_two_byte = 1'b1; is_alu = 1'b1; alu_select = ALU_MUL;  end
            OP_AND:  begin is_two_byte = 1'b1; is_alu = 1'b1; alu_select = ALU_AND;  end
            OP_OR:   begin is_two_byte = 1'b1; is_alu = 1'b1; alu_select = ALU_OR;   end
            OP_NOT:  begin is_alu = 1'b1; alu_select = ALU_NOT; end
            OP_LDI:  begin is_two_byte = 1'b1; is_alu = 1'b1; alu_select = ALU_PASS; end
`ifdef SEQ_BRANCH_EN
            OP_JMP, OP_JZ: begin is_two_byte = 1'b1; is_branch = 1'b1; end
`endif
            OP_HALT: is_halt = 1'b1;
            default: is_illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer driving the ALU and accumulator.
// Branch support (JMP/JZ) follows SEQ_BRANCH_EN through instr_decode.
module instr_sequencer
    import cpu_pkg::*;
#(
    parameter int unsigned     PC_W     = 8,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst_n,
    output logic            imem_req,
    output logic [PC_W-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [7:0]      imem_data,
    output logic [3:0]      alu_component_select,
    output logic [7:0]      alu_input_1,
    output logic [7:0]      alu_input_2,
    input  logic [7:0]      alu_result,
    input  logic [7:0]      acc_read,
    output logic            acc_write_bit,
    output logic [7:0]      acc_write_port,
    output logic            halted,
    output logic            illegal_op
);

    seq_state_t state, next_state;

    logic [PC_W-1:0]      pc, pc_n;
    logic [7:0]           imm, imm_n;
    logic [OPCODE_W-1:0]  opcode, opcode_n;
    logic [ALU_SEL_W-1:0] sel_n;
    logic [7:0]           in1_n, in2_n;
    logic                 illegal_n;

    logic                 dec_two_byte;
    logic                 dec_alu;
    logic [ALU_SEL_W-1:0] dec_sel;
    logic                 dec_branch;
    logic                 dec_halt;
    logic                 dec_illegal;

    instr_decode u_decode (
        .opcode      (opcode),
        .is_two_byte (dec_two_byte),
        .is_alu      (dec_alu),
        .alu_select  (dec_sel),
        .is_branch   (dec_branch),
        .is_halt     (dec_halt),
        .is_illegal  (dec_illegal)
    );

    always_comb begin
        next_state = state;
        pc_n       = pc;
        imm_n      = imm;
        opcode_n   = opcode;
        sel_n      = alu_component_select;
        in1_n      = alu_input_1;
        in2_n      = alu_input_2;
        illegal_n  = illegal_op;
        unique case (state)
            ST_FETCH: begin
                if (imem_req && imem_ack) begin
                    opcode_n   = imem_data[7:4];
                    pc_n       = pc + PC_W'(1);
                    next_state = ST_DECODE;
                end
            end
            ST_DECODE: begin
                if (dec_halt) begin
                    next_state = ST_HALT;
                end else if (dec_two_byte) begin
                    next_state = ST_IMM;
                end else if (dec_alu) begin
                    next_state = ST_EXEC;
                    sel_n      = dec_sel;
                    in1_n      = acc_read;
                    in2_n      = imm;
                end else begin
                    next_state = ST_FETCH;
                    illegal_n  = illegal_op | dec_illegal;
                end
            end
            ST_IMM: begin
                if (imem_req && imem_ack) begin
                    imm_n = imem_data;
                    pc_n  = pc + PC_W'(1);
                    if (dec_branch) begin
                        next_state = ST_FETCH;
                        if (opcode == OP_JMP || acc_read == '0)
                            pc_n = PC_W'(imem_data);
                    end else begin
                        next_state = ST_EXEC;
                        sel_n      = dec_sel;
                        in2_n      = imem_data;
                        in1_n      = (opcode == OP_LDI) ? imem_data : acc_read;
                    end
                end
            end
            ST_EXEC:  next_state = ST_FETCH;
            ST_HALT:  next_state = ST_HALT;
            default:  next_state = ST_FETCH;
        endcase
    end

    // Request, address and strobes are registered from the next state so they
    // line up with the state they belong to without combinational outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state                <= ST_FETCH;
            pc                   <= RESET_PC;
            imm                  <= '0;
            opcode               <= '0;
            imem_req             <= 1'b0;
            imem_addr            <= '0;
            alu_component_select <= '0;
            alu_input_1          <= '0;
            alu_input_2          <= '0;
            acc_write_bit        <= 1'b0;
            halted               <= 1'b0;
            illegal_op           <= 1'b0;
        end else begin
            state                <= next_state;
            pc                   <= pc_n;
            imm                  <= imm_n;
            opcode               <= opcode_n;
            imem_req             <= (next_state == ST_FETCH) || (next_state == ST_IMM);
            imem_addr            <= pc_n;
            alu_component_select <= sel_n;
            alu_input_1          <= in1_n;
            alu_input_2          <= in2_n;
            acc_write_bit        <= (next_state == ST_EXEC);
            halted               <= (next_state == ST_HALT);
            illegal_op           <= illegal_n;
        end
    end

    assign acc_write_port = acc_write_bit ? alu_result : '0;

endmodule

// File: tb/tb_instr_sequencer.sv
// Scoreboard bench for instr_sequencer: an ISA-level reference model predicts
// accumulator writes, cycle counts, halt address and illegal flag.
module tb_instr_sequencer;

    logic clk = 1'b0;
    always #5 clk = ~clk;

`ifdef SEQ_BRANCH_EN
    localparam bit BR_EN = 1'b1;
`else
    localparam bit BR_EN = 1'b0;
`endif

    logic       rst_n = 1'b0;
    logic       imem_req;
    logic [7:0] imem_addr;
    logic       imem_ack  = 1'b0;
    logic [7:0] imem_data = 8'h00;
    logic [3:0] alu_sel;
    logic [7:0] alu_in1, alu_in2, alu_result, acc_q, acc_wport;
    logic       acc_wbit, halted, illegal_op;

    logic       rst_w_n = 1'b0;
    logic       req_w;
    logic [7:0] addr_w;
    logic       ack_w  = 1'b0;
    logic [7:0] data_w = 8'h00;
    logic [3:0] sel_w;
    logic [7:0] in1_w, in2_w, res_w, acc_w, wport_w;
    logic       wbit_w, halted_w, illegal_w;

    instr_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
        .clk(clk), .rst_n(rst_n), .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_data(imem_data), .alu_component_select(alu_sel),
        .alu_input_1(alu_in1), .alu_input_2(alu_in2), .alu_result(alu_result),
        .acc_read(acc_q), .acc_write_bit(acc_wbit), .acc_write_port(acc_wport),
        .halted(halted), .illegal_op(illegal_op)
    );

    instr_sequencer #(.PC_W(8), .RESET_PC(8'hFE)) dut_wrap (
        .clk(clk), .rst_n(rst_w_n), .imem_req(req_w), .imem_addr(addr_w),
        .imem_ack(ack_w), .imem_data(data_w), .alu_component_select(sel_w),
        .alu_input_1(in1_w), .alu_input_2(in2_w), .alu_result(res_w),
        .acc_read(acc_w), .acc_write_bit(wbit_w), .acc_write_port(wport_w),
        .halted(halted_w), .illegal_op(illegal_w)
    );

    function automatic logic [7:0] alu_f(input logic [3:0] s, input logic [7:0] a, input logic [7:0] b);
        case (s)
            4'b0000: return a + b;
            4'b0001: return a * b;
            4'b0010: return a & b;
            4'b0011: return a | b;
            4'b0100: return ~a;
            4'b0111: return a;
            default: return 8'h00;
        endcase
    endfunction

    assign alu_result = alu_f(alu_sel, alu_in1, alu_in2);
    assign res_w      = alu_f(sel_w, in1_w, in2_w);

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) acc_q <= 8'h00;
        else if (acc_wbit) acc_q <= acc_wport;

    always_ff @(posedge clk or negedge rst_w_n)
        if (!rst_w_n) acc_w <= 8'h00;
        else if (wbit_w) acc_w <= wport_w;

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, req, $time);
        end
    endtask

    typedef struct packed { logic [3:0] sel; logic [7:0] val; } exp_t;
    exp_t        exp_q[$];
    logic [7:0]  mem [256];
    logic [7:0]  prog[$];
    int unsigned waits = 0;
    int          exp_cycles;
    bit          exp_halt, exp_illegal;
    logic [7:0]  exp_halt_addr;
    logic [7:0]  last_ack_addr = 8'h00;

    // ISA-level reference: one loop iteration per instruction.
    task automatic model_run(input logic [7:0] start_pc, input int max_instr);
        logic [7:0] pc, acc, imm, a;
        logic [3:0] op, s;
        bit         done;
        int         fetch;
        pc = start_pc; acc = 8'h00; imm = 8'h00; done = 1'b0;
        fetch = 1 + int'(waits);
        exp_cycles = 0; exp_halt = 1'b0; exp_illegal = 1'b0; exp_halt_addr = 8'h00;
        for (int n = 0; n < max_instr && !done; n++) begin
            a  = pc;
            op = mem[pc][7:4];
            pc = pc + 8'd1;
            exp_cycles += fetch + 1;
            case (op)
                4'h0: ;
                4'hF: begin done = 1'b1; exp_halt = 1'b1; exp_halt_addr = a; end
                4'h5: begin
                    acc = ~acc;
                    exp_cycles += 1;
                    exp_q.push_back('{sel: 4'b0100, val: acc});
                end
                4'h1, 4'h2, 4'h3, 4'h4, 4'h6: begin
                    imm = mem[pc];
                    pc  = pc + 8'd1;
                    exp_cycles += fetch + 1;
                    case (op)
                        4'h1:    begin acc = acc + imm; s = 4'b0000; end
                        4'h2:    begin acc = acc * imm; s = 4'b0001; end
                        4'h3:    begin acc = acc & imm; s = 4'b0010; end
                        4'h4:    begin acc = acc | imm; s = 4'b0011; end
                        default: begin acc = imm;       s = 4'b0111; end
                    endcase
                    exp_q.push_back('{sel: s, val: acc});
                end
                4'h7, 4'h8: begin
                    if (BR_EN) begin
                        imm = mem[pc];
                        pc  = pc + 8'd1;
                        exp_cycles += fetch;
                        if (op == 4'h7 || acc == 8'h00) pc = imm;
                    end else begin
                        exp_illegal = 1'b1;
                    end
                end
                default: exp_illegal = 1'b1;
            endcase
        end
    endtask

    // Memory responder: inserts `waits` cycles before each ack, garbage otherwise.
    int unsigned wcnt = 0;
    logic [7:0]  held_addr = 8'h00;
    always @(negedge clk) begin
        if (imem_req) begin
            if (wcnt == 0) held_addr = imem_addr;
            else check("addr_stable", 32'(imem_addr), 32'(held_addr));
            if (wcnt >= waits) begin
                imem_ack      = 1'b1;
                imem_data     = mem[imem_addr];
                last_ack_addr = imem_addr;
                wcnt          = 0;
            end else begin
                imem_ack  = 1'b0;
                imem_data = 8'($urandom);
                wcnt++;
            end
        end else begin
            imem_ack  = 1'($urandom_range(0, 1));
            imem_data = 8'($urandom);
            wcnt      = 0;
        end
    end

    // Monitor: every accumulator write strobe consumes one expected entry.
    always @(negedge clk) begin
        exp_t e;
        if (acc_wbit) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL acc_write_unexpected: got sel %b data %h, required no write", alu_sel, acc_wport);
            end else begin
                e = exp_q.pop_front();
                if ({alu_sel, acc_wport} !== {e.sel, e.val}) begin
                    errors++;
                    $display("FAIL acc_write: got sel %b data %h, required sel %b data %h", alu_sel, acc_wport, e.sel, e.val);
                end
            end
        end
    end

    logic [7:0] mem_w [256];
    logic [7:0] last_w = 8'h55;
    int         writes_w = 0;
    always @(negedge clk) begin
        ack_w  = req_w;
        data_w = mem_w[addr_w];
        if (req_w) last_w = addr_w;
        if (wbit_w) begin
            writes_w++;
            check("wrap_acc_write", 32'(wport_w), 32'h07);
        end
    end

    task automatic load_prog();
        for (int a = 0; a < 256; a++) mem[a] = 8'hF0;
        for (int i = 0; i < prog.size(); i++) mem[i] = prog[i];
    endtask

    task automatic run_prog(input int unsigned w, input int max_instr);
        bit got_req;
        rst_n = 1'b0;
        waits = w;
        exp_q.delete();
        model_run(8'h00, max_instr);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        got_req = 1'b0;
        for (int i = 0; i < 6 && !got_req; i++) begin
            @(negedge clk);
            if (imem_req) got_req = 1'b1;
        end
        check("req_after_reset", 32'(got_req), 32'd1);
        if (got_req) begin
            check("first_fetch_addr", 32'(imem_addr), 32'h00);
            for (int c = 1; c <= exp_cycles + 1; c++) begin
                @(negedge clk);
                if (exp_halt && c == exp_cycles - 1) check("halted_early", 32'(halted), 32'd0);
                if (exp_halt && c == exp_cycles)     check("halt_cycle", 32'(halted), 32'd1);
            end
            check("pending_writes", 32'(exp_q.size()), 32'd0);
            check("halted", 32'(halted), 32'(exp_halt));
            check("illegal_op", 32'(illegal_op), 32'(exp_illegal));
            if (exp_halt) begin
                check("halt_addr", 32'(last_ack_addr), 32'(exp_halt_addr));
                check("req_low_in_halt", 32'(imem_req), 32'd0);
            end
        end
        rst_n = 1'b0;
        exp_q.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        bit got_req;
        for (int a = 0; a < 256; a++) mem_w[a] = 8'hF0;
        mem_w[8'hFE] = 8'h60;
        mem_w[8'hFF] = 8'h07;
        for (int a = 0; a < 256; a++) mem[a] = 8'hF0;

        repeat (3) @(negedge clk);
        check("rst_req", 32'(imem_req), 32'd0);
        check("rst_addr", 32'(imem_addr), 32'd0);
        check("rst_sel", 32'(alu_sel), 32'd0);
        check("rst_in1", 32'(alu_in1), 32'd0);
        check("rst_in2", 32'(alu_in2), 32'd0);
        check("rst_wbit", 32'(acc_wbit), 32'd0);
        check("rst_halted", 32'(halted), 32'd0);
        check("rst_illegal", 32'(illegal_op), 32'd0);
        rst_w_n = 1'b1;

        prog = '{8'h60, 8'h05, 8'h10, 8'h03, 8'hF0};
        load_prog();
        run_prog(0, 40);
        run_prog(3, 40);

        prog = '{8'h60, 8'h0C, 8'h30, 8'h0A, 8'h40, 8'h01, 8'h50, 8'hF0};
        load_prog();
        run_prog(0, 40);
        run_prog(2, 40);

        prog = '{8'h60, 8'hFF, 8'h20, 8'h02, 8'hF0};
        load_prog();
        run_prog(1, 40);

        prog = '{8'h90, 8'h60, 8'h33, 8'hA7, 8'h10, 8'h01, 8'hF0};
        load_prog();
        run_prog(0, 40);

        prog = '{8'h60, 8'h00, 8'h80, 8'h06, 8'hF0, 8'h00, 8'h70, 8'h00};
        load_prog();
        run_prog(0, 20);

        // Reset while a fetch is waiting on ack, then a clean restart.
        prog = '{8'h60, 8'h0C, 8'h30, 8'h0A, 8'h40, 8'h01, 8'h50, 8'hF0};
        load_prog();
        waits = 3;
        exp_q.delete();
        @(negedge clk);
        rst_n = 1'b1;
        got_req = 1'b0;
        for (int i = 0; i < 6 && !got_req; i++) begin
            @(negedge clk);
            if (imem_req) got_req = 1'b1;
        end
        @(negedge clk);
        check("req_before_midreset", 32'(imem_req), 32'd1);
        rst_n = 1'b0;
        #1;
        check("req_async_drop", 32'(imem_req), 32'd0);
        check("addr_async_clear", 32'(imem_addr), 32'd0);
        repeat (3) @(negedge clk);
        run_prog(3, 40);

        for (int t = 0; t < 8; t++) begin
            prog.delete();
            for (int a = 0; a < 40; a++) begin
                logic [7:0] b;
                b = 8'($urandom);
                if (b[7:4] == 4'hF) b[7:4] = 4'h0;
                prog.push_back(b);
            end
            load_prog();
            run_prog(32'($urandom_range(0, 3)), 30);
        end

        check("wrap_writes", 32'(writes_w), 32'd1);
        check("wrap_halted", 32'(halted_w), 32'd1);
        check("wrap_halt_addr", 32'(last_w), 32'h00);
        check("wrap_acc", 32'(acc_w), 32'h07);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
